// File: rtl/pipe_reg_d.sv
// pipe_reg_d: fetch-to-decode pipeline register with bubble/stall control,
// saturating activity counters and a sticky stall watchdog.
module pipe_reg_d #(
  parameter int          XLEN        = 64,
  parameter int          STALL_LIMIT = 1024,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [31:0]     fetch_instr,
  input  logic            fetch_exc,
  input  logic            regD_stall,
  input  logic            regD_bubble,
  output logic            decode_valid,
  output logic [XLEN-1:0] decode_pc,
  output logic [31:0]     decode_instr,
  output logic            decode_exc,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     bubble_cnt,
  output logic            stall_timeout
);
  localparam logic [31:0] LIMIT = 32'(STALL_LIMIT);
  typedef enum logic {RUN, TIMEOUT} state_t;
  state_t          state_q, state_d;
  logic            valid_q, valid_d, exc_q, exc_d, stall;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d, stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d, run_q, run_d;
  always_comb begin
    stall        = regD_stall && !regD_bubble;
    valid_d      = regD_bubble ? 1'b0 : stall ? valid_q : fetch_valid;
    pc_d         = regD_bubble ? '0 : stall ? pc_q : fetch_pc;
    instr_d      = regD_bubble ? NOP_INSTR : stall ? instr_q : fetch_valid ? fetch_instr : NOP_INSTR;
    exc_d        = regD_bubble ? 1'b0 : stall ? exc_q : fetch_valid && fetch_exc;
    stall_cnt_d  = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    bubble_cnt_d = (regD_bubble && bubble_cnt_q != '1) ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
    run_d        = !stall ? '0 : (run_q >= LIMIT) ? run_q : run_q + 32'd1;
    // watchdog only observes; it never feeds back into the datapath
    state_d      = (state_q == TIMEOUT || run_d >= LIMIT) ? TIMEOUT : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
      exc_q        <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      run_q        <= '0;
      state_q      <= RUN;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      exc_q        <= exc_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      run_q        <= run_d;
      state_q      <= state_d;
    end
  end
  assign decode_valid  = valid_q;
  assign decode_pc     = pc_q;
  assign decode_instr  = instr_q;
  assign decode_exc    = exc_q;
  assign stall_cnt     = stall_cnt_q;
  assign bubble_cnt    = bubble_cnt_q;
  assign stall_timeout = (state_q == TIMEOUT);
endmodule

// File: doc/pipe_reg_d.md
PIPE_REG_D -- requirements
Module: pipe_reg_d

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 64, PC width.
- STALL_LIMIT, 1024, consecutive stall cycles before timeout flag.
- NOP_INSTR, 32'h00000013, instruction word loaded on bubble/reset.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- fetch_valid, in, 1, fetch stage presents an instruction.
- fetch_pc, in, XLEN, fetch PC.
- fetch_instr, in, 32, fetch instruction word.
- fetch_exc, in, 1, fetch-side exception (misaligned/access fault).
- regD_stall, in, 1, hold decode register.
- regD_bubble, in, 1, flush decode register.
- decode_valid, out, 1, decode stage holds a live instruction.
- decode_pc, out, XLEN, registered PC.
- decode_instr, out, 32, registered instruction.
- decode_exc, out, 1, registered exception flag.
- stall_cnt, out, 32, total cycles spent stalled.
- bubble_cnt, out, 32, total bubbles inserted.
- stall_timeout, out, 1, sticky: stall held STALL_LIMIT consecutive cycles.

Function
REQ-003 Each cycle SHALL take exactly one action, in priority order: rst, then bubble, then stall, then load.
REQ-004 A bubble (regD_bubble=1) SHALL load decode_valid=0, decode_instr=NOP_INSTR, decode_pc=0, decode_exc=0, even when regD_stall=1 in the same cycle.
REQ-005 A stall (regD_stall=1, regD_bubble=0) SHALL hold all four decode_* outputs unchanged.
REQ-006 A load (both control inputs 0) SHALL capture fetch_pc, fetch_instr and fetch_exc.
REQ-007 On a load, decode_valid SHALL equal fetch_valid.
REQ-008 On a load with fetch_valid=0, the stage SHALL still capture fetch_pc, SHALL force decode_instr=NOP_INSTR, and SHALL force decode_exc=0.
REQ-009 Latency: a loaded value SHALL appear on decode_* one cycle after the capturing edge; no combinational path from fetch_* to decode_*.
REQ-010 stall_cnt SHALL increment by 1 each cycle regD_stall=1 and regD_bubble=0, and SHALL saturate at 32'hFFFFFFFF.
REQ-011 bubble_cnt SHALL increment by 1 each cycle regD_bubble=1, and SHALL saturate at 32'hFFFFFFFF.
REQ-012 A 32-bit run counter SHALL count consecutive stall cycles; it SHALL clear on any non-stall cycle and SHALL saturate at STALL_LIMIT.
REQ-013 Watchdog FSM: states RUN and TIMEOUT.
- RUN->TIMEOUT on the edge at which the run counter reaches STALL_LIMIT.
- TIMEOUT is exited only by rst.
- stall_timeout=1 exactly in TIMEOUT.
REQ-014 stall_timeout SHALL be observation-only and SHALL NOT alter datapath behaviour.
REQ-015 Mid-operation reset SHALL override stall and bubble on that edge.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL set:
- decode_valid=0, decode_pc=0, decode_instr=NOP_INSTR, decode_exc=0
- stall_cnt=0, bubble_cnt=0, run counter=0
- FSM=RUN, stall_timeout=0
REQ-017 Outputs SHALL be defined one cycle after the first reset edge; no asynchronous clear.

Verification
REQ-018 Load: after reset, fetch_valid=1, pc=0x80000000, instr=0x00500093, controls 0 -> next cycle decode_valid=1, decode_pc=0x80000000, decode_instr=0x00500093.
REQ-019 Stall hold: load A, then regD_stall=1 for 3 cycles while fetch presents B -> decode shows A for all 3 cycles, stall_cnt=3, then B one cycle after stall drops.
REQ-020 Bubble priority: regD_stall=1 and regD_bubble=1 together -> next cycle decode_valid=0, decode_instr=0x00000013, bubble_cnt+=1, stall_cnt unchanged.
REQ-021 Exception masking: fetch_valid=0, fetch_exc=1, load -> decode_valid=0, decode_exc=0, decode_instr=0x00000013.
REQ-022 Timeout: STALL_LIMIT=4, regD_stall=1 for 4 cycles -> stall_timeout=1 after the 4th edge; it stays 1 after stall drops and clears only on rst.
REQ-023 Reset mid-stall: rst=1 with regD_stall=1 and stall_cnt=7 -> next cycle every output equals its REQ-016 reset value.
